// File: rtl/fetch_stage_if.sv
// Instruction-memory and IF/ID bundle between fetch and its neighbours.
// The fetch stage is the master of the memory address and the IF/ID fields.
interface fetch_stage_if;
    logic [14:0] pc_f;
    logic [19:0] instr_f;
    logic [19:0] instr_d;
    logic [14:0] pc_d;
    logic [14:0] pc_plus1_d;
    logic        valid_d;

    modport master (
        output pc_f,
        input  instr_f,
        output instr_d,
        output pc_d,
        output pc_plus1_d,
        output valid_d
    );

    modport slave (
        input  pc_f,
        output instr_f,
        input  instr_d,
        input  pc_d,
        input  pc_plus1_d,
        input  valid_d
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills IF/ID, freezes on HALT.
// A redirect from Execute overrides stall and cancels a wrong-path halt.
module fetch_stage #(
    parameter logic [14:0] RESET_PC  = 15'h0000,
    parameter logic [19:0] HALT_WORD = 20'hFFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_f,
    input  logic          stall_d,
    input  logic          flush_d,
    input  logic          pc_src_e,
    input  logic [14:0]   pc_target_e,
    fetch_stage_if.master bus,
    output logic          halted,
    output logic [15:0]   fetch_count
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    typedef struct packed {
        logic [19:0] instr;
        logic [14:0] pc;
        logic [14:0] pc_plus1;
        logic        valid;
    } if_id_t;

    logic [0:0]  state_q, state_n;
    logic [14:0] pc_q, pc_n, pc_plus1_f;
    if_id_t      ifid_q, ifid_n;
    logic [15:0] cnt_q, cnt_n;
    logic        halt_hit;
    logic        capture;

    assign pc_plus1_f = pc_q + 15'd1;

    assign halt_hit = (state_q == RUN) && (bus.instr_f == HALT_WORD)
                      && !stall_f && !pc_src_e;

    assign capture = !flush_d && !stall_d
                     && (state_q == RUN) && !stall_f;

    always_comb begin
        state_n = state_q;
        if (pc_src_e)
            state_n = RUN;
        else if (halt_hit)
            state_n = HALTED;
    end

    always_comb begin
        pc_n = pc_plus1_f;
        priority case (1'b1)
            pc_src_e:                        pc_n = pc_target_e;
            (state_q == HALTED) || halt_hit: pc_n = pc_q;
            stall_f:                         pc_n = pc_q;
            default:                         pc_n = pc_plus1_f;
        endcase
    end

    always_comb begin
        ifid_n = '0;
        priority case (1'b1)
            flush_d: ifid_n = '0;
            stall_d: ifid_n = ifid_q;
            capture: begin
                ifid_n.instr    = bus.instr_f;
                ifid_n.pc       = pc_q;
                ifid_n.pc_plus1 = pc_plus1_f;
                ifid_n.valid    = 1'b1;
            end
            default: ifid_n = '0;
        endcase
    end

    // Saturate rather than wrap so long runs never report a small count
    always_comb begin
        cnt_n = cnt_q;
        if (capture && cnt_q != 16'hFFFF)
            cnt_n = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            ifid_q  <= ifid_n;
            cnt_q   <= cnt_n;
        end
    end

    assign bus.pc_f       = pc_q;
    assign bus.instr_d    = ifid_q.instr;
    assign bus.pc_d       = ifid_q.pc;
    assign bus.pc_plus1_d = ifid_q.pc_plus1;
    assign bus.valid_d    = ifid_q.valid;
    assign halted         = (state_q == HALTED);
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational memory model.
// Memory word at address a is a+1, or the HALT word at 7 when enabled.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [14:0] pc_target_e;
    logic        halted;
    logic [15:0] fetch_count;
    logic        halt_en;

    int errors = 0;
    int checks = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .bus         (bus),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign bus.instr_f = (halt_en && bus.pc_f == 15'd7)
                         ? 20'hFFFFF
                         : {5'b0, bus.pc_f} + 20'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        pc_src_e    = 1'b0;
        pc_target_e = 15'h0;
    endtask

    task automatic redirect(input logic [14:0] tgt);
        pc_src_e    = 1'b1;
        pc_target_e = tgt;
        flush_d     = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        halt_en = 1'b0;
        idle();
        #1;
        chk("rst_pc", 32'(bus.pc_f), 32'h0);
        chk("rst_valid", 32'(bus.valid_d), 32'h0);
        repeat (3) step();
        chk("rst_hold_pc", 32'(bus.pc_f), 32'h0);
        chk("rst_count", 32'(fetch_count), 32'h0);
        reset = 1'b1;

        step();
        chk("e1_instr", 32'(bus.instr_d), 32'h1);
        chk("e1_pc_d", 32'(bus.pc_d), 32'h0);
        chk("e1_pc1_d", 32'(bus.pc_plus1_d), 32'h1);
        chk("e1_valid", 32'(bus.valid_d), 32'h1);
        step();
        step();
        chk("e3_count", 32'(fetch_count), 32'd3);
        chk("e3_pc", 32'(bus.pc_f), 32'd3);
        step();
        step();
        chk("pre_stall_pc", 32'(bus.pc_f), 32'd5);

        stall_f = 1'b1;
        stall_d = 1'b1;
        step();
        step();
        chk("stall_pc", 32'(bus.pc_f), 32'd5);
        chk("stall_instr", 32'(bus.instr_d), 32'h5);
        chk("stall_pc_d", 32'(bus.pc_d), 32'd4);
        chk("stall_count", 32'(fetch_count), 32'd5);
        idle();
        step();
        chk("unstall_pc", 32'(bus.pc_f), 32'd6);
        chk("unstall_instr", 32'(bus.instr_d), 32'h6);
        chk("unstall_count", 32'(fetch_count), 32'd6);

        halt_en = 1'b1;
        step();
        chk("pre_halt_pc", 32'(bus.pc_f), 32'd7);
        step();
        chk("halt_instr", 32'(bus.instr_d), 32'hFFFFF);
        chk("halt_pc_d", 32'(bus.pc_d), 32'd7);
        chk("halt_valid", 32'(bus.valid_d), 32'h1);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_pc", 32'(bus.pc_f), 32'd7);
        chk("halt_count", 32'(fetch_count), 32'd8);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halted_valid", 32'(bus.valid_d), 32'h0);
            chk("halted_count", 32'(fetch_count), 32'd8);
            chk("halted_pc", 32'(bus.pc_f), 32'd7);
        end

        redirect(15'h0010);
        step();
        chk("unhalt_flag", 32'(halted), 32'h0);
        chk("unhalt_pc", 32'(bus.pc_f), 32'h10);
        chk("unhalt_valid", 32'(bus.valid_d), 32'h0);
        idle();
        halt_en = 1'b0;
        step();
        chk("tgt_pc_d", 32'(bus.pc_d), 32'h10);
        chk("tgt_instr", 32'(bus.instr_d), 32'h11);
        chk("tgt_count", 32'(fetch_count), 32'd9);

        redirect(15'h0040);
        stall_f = 1'b1;
        step();
        chk("redir_pc", 32'(bus.pc_f), 32'h40);
        chk("redir_valid", 32'(bus.valid_d), 32'h0);
        idle();
        step();
        chk("redir_pc_d", 32'(bus.pc_d), 32'h40);
        chk("redir_valid2", 32'(bus.valid_d), 32'h1);
        chk("redir_count", 32'(fetch_count), 32'd10);

        redirect(15'h7FFF);
        step();
        chk("wrap_pre_pc", 32'(bus.pc_f), 32'h7FFF);
        idle();
        step();
        chk("wrap_pc_d", 32'(bus.pc_d), 32'h7FFF);
        chk("wrap_pc1_d", 32'(bus.pc_plus1_d), 32'h0);
        chk("wrap_pc", 32'(bus.pc_f), 32'h0);
        chk("wrap_count", 32'(fetch_count), 32'd11);

        for (int i = 0; i < 70000 && fetch_count != 16'hFFFF; i++)
            step();
        chk("sat_reach", 32'(fetch_count), 32'hFFFF);
        repeat (3) step();
        chk("sat_hold", 32'(fetch_count), 32'hFFFF);
        chk("sat_valid", 32'(bus.valid_d), 32'h1);

        halt_en = 1'b1;
        redirect(15'h0007);
        step();
        idle();
        step();
        chk("pre_rst_halt", 32'(halted), 32'h1);
        stall_d = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pc", 32'(bus.pc_f), 32'h0);
        chk("arst_instr", 32'(bus.instr_d), 32'h0);
        chk("arst_pc_d", 32'(bus.pc_d), 32'h0);
        chk("arst_pc1_d", 32'(bus.pc_plus1_d), 32'h0);
        chk("arst_valid", 32'(bus.valid_d), 32'h0);
        chk("arst_halted", 32'(halted), 32'h0);
        chk("arst_count", 32'(fetch_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter (PCF) that drives the memory's 15-bit word address, and receives the 20-bit instruction word back.
- Registers the instruction into the IF/ID pipeline register for decode.
- Handles stall, flush, branch/jump redirect from Execute, and a HALT instruction that freezes fetch.

Parameters:
- RESET_PC, 15'h0000: PC value loaded on reset.
- HALT_WORD, 20'hFFFFF: instruction encoding that halts fetch.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- stall_f  in  1  hold PC (hazard unit).
- stall_d  in  1  hold IF/ID register.
- flush_d  in  1  insert bubble into IF/ID.
- pc_src_e  in  1  redirect request from Execute (taken branch/jump).
- pc_target_e  in  15  redirect target word address.
- instr_f  in  20  instruction word from instruction memory (rd).
- pc_f  out  15  current PC; drives instruction memory address (a).
- instr_d  out  20  IF/ID instruction.
- pc_d  out  15  IF/ID PC of that instruction.
- pc_plus1_d  out  15  IF/ID PC+1.
- valid_d  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch frozen by HALT.
- fetch_count  out  16  number of valid instructions delivered to decode, saturating.

Behaviour:
- Reset (asynchronous, active-low; takes effect immediately, including mid-operation, and overrides every other input):
  - pc_f=RESET_PC; instr_d=0, pc_d=0, pc_plus1_d=0, valid_d=0; halted=0; fetch_count=0; state=RUN.
- Arithmetic:
  - pc_plus1_f = pc_f+1, 15-bit modulo; 15'h7FFF wraps to 15'h0000.
  - fetch_count saturates at 16'hFFFF.
- State machine, two states RUN and HALTED; halted=1 iff state==HALTED.
  - RUN->HALTED: instr_f==HALT_WORD and stall_f=0 and pc_src_e=0.
  - HALTED->RUN: pc_src_e=1 (wrong-path halt cancelled by redirect).
  - No other transitions.
- PC next value, in priority order:
  1. pc_src_e=1 -> pc_target_e. This overrides stall_f and HALTED.
  2. HALTED, or the RUN->HALTED transition cycle -> hold. PC stays at the HALT address.
  3. stall_f=1 -> hold.
  4. otherwise -> pc_plus1_f.
- IF/ID register, in priority order:
  1. flush_d=1 -> bubble (instr_d=0, pc_d=0, pc_plus1_d=0, valid_d=0). Flush wins over stall_d.
  2. stall_d=1 -> hold all IF/ID fields.
  3. state==HALTED, or stall_f=1 -> bubble.
  4. otherwise -> capture instr_d=instr_f, pc_d=pc_f, pc_plus1_d=pc_plus1_f, valid_d=1.
  - The HALT word itself is captured as a normal valid instruction in the cycle it causes the RUN->HALTED transition.
- fetch_count increments by 1 on each edge where case 4 captures.
- Latency:
  - instr_f is combinational from pc_f via the memory.
  - The instruction at PC n appears on instr_d one edge after pc_f==n with no stall.
  - Redirect: target appears on pc_f one edge after pc_src_e; the target instruction reaches instr_d on the following edge.
  - The hazard unit asserts flush_d alongside pc_src_e to kill the wrong-path instruction.
- No internal address range check: pc_f beyond memory depth is passed through unchanged.

Test Plan:
- Reset low 3 cycles, release; memory holds 0x00001,0x00002,0x00003 at 0..2:
  - during reset: pc_f=0, valid_d=0.
  - edge 1: instr_d=0x00001, pc_d=0, pc_plus1_d=1.
  - edge 3: fetch_count=3.
- stall_f=1 and stall_d=1 for 2 cycles at pc_f=5 -> pc_f stays 5, IF/ID frozen, fetch_count unchanged. Release -> pc_f=6 next edge.
- pc_src_e=1 with pc_target_e=0x0040 and flush_d=1, also stall_f=1 -> pc_f=0x0040 next edge, valid_d=0. Following edge: pc_d=0x0040, valid_d=1.
- HALT_WORD at address 0x0007:
  - after capture: instr_d=0xFFFFF, halted=1, pc_f held at 7.
  - subsequent cycles: valid_d=0 and fetch_count constant for 10 cycles.
  - then pc_src_e=1 with target 0x0010 -> halted=0, pc_f=0x0010.
- Start at pc_f=0x7FFF -> pc_plus1_d=0x0000, next pc_f=0x0000. Also force fetch_count to 0xFFFF -> it stays 0xFFFF.
- Assert reset low asynchronously mid-cycle while halted with stall_d=1 -> all outputs return to reset values immediately, without waiting for a clk edge.
